// File: rtl/syn_accum.sv
// Synaptic current accumulator: latches a spike vector on start, sweeps a
// synchronous weight memory, and sums the weights of active inputs with
// saturation. The result is presented on a valid/ready output.
module syn_accum #(
  parameter int unsigned N_PRE  = 16,
  parameter int unsigned W_BITS = 16,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_PRE-1:0]         spike_vec,
  output logic [$clog2(N_PRE)-1:0] w_addr,
  input  logic signed [W_BITS-1:0] w_data,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc
);

  localparam int unsigned IDX_W = $clog2(N_PRE);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PRE - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [N_PRE-1:0]        spikes, spikes_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [ACC_W-1:0] out_acc_nxt;
  logic                    busy_nxt;
  logic                    out_valid_nxt;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [ACC_W-1:0] acc_sat_c;
  logic                    acc_en_c;
  logic signed [ACC_W-1:0] acc_upd_c;

  // Weight arriving now belongs to the address issued one cycle earlier.
  always_comb begin
    acc_en_c = 1'b0;
    if (state == FETCH && idx != '0)
      acc_en_c = spikes[idx - IDX_W'(1)];
    else if (state == DRAIN)
      acc_en_c = spikes[N_PRE-1];
  end

  // Widened add with clamp to the signed ACC_W range.
  always_comb begin
    sum_c = $signed({acc[ACC_W-1], acc}) +
            $signed({{(SUM_W-W_BITS){w_data[W_BITS-1]}}, w_data});
    if (sum_c[SUM_W-1] != sum_c[SUM_W-2])
      acc_sat_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
    else
      acc_sat_c = sum_c[ACC_W-1:0];
    acc_upd_c = acc_en_c ? acc_sat_c : acc;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    spikes_nxt    = spikes;
    acc_nxt       = acc;
    busy_nxt      = busy;
    out_valid_nxt = out_valid;
    out_acc_nxt   = out_acc;
    case (state)
      IDLE: begin
        if (start) begin
          spikes_nxt = spike_vec;
          acc_nxt    = '0;
          idx_nxt    = '0;
          busy_nxt   = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        acc_nxt = acc_upd_c;
        if (idx == LAST_IDX) begin
          idx_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      DRAIN: begin
        acc_nxt       = acc_upd_c;
        out_acc_nxt   = acc_upd_c;
        out_valid_nxt = 1'b1;
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      spikes    <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      spikes    <= spikes_nxt;
      acc       <= acc_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
      out_acc   <= out_acc_nxt;
    end
  end

  assign w_addr = idx;

endmodule

// File: tb/tb_syn_accum.sv
// Scoreboard bench for syn_accum: two instances (default config and a
// narrow-accumulator config), behavioural weight memories and a sum model.
module tb_syn_accum;

  logic clk;
  logic rst_n;

  // Instance 0: N_PRE=16, ACC_W=32
  logic               start0, busy0, out_valid0, out_ready0;
  logic [15:0]        spike0;
  logic [3:0]         w_addr0;
  logic signed [15:0] w_data0;
  logic signed [31:0] out_acc0;

  // Instance 1: N_PRE=32, ACC_W=20
  logic               start1, busy1, out_valid1, out_ready1;
  logic [31:0]        spike1;
  logic [4:0]         w_addr1;
  logic signed [15:0] w_data1;
  logic signed [19:0] out_acc1;

  int wt0 [32];
  int wt1 [32];
  longint q0 [$];
  longint q1 [$];
  int total = 0;
  int bad   = 0;

  syn_accum #(.N_PRE(16), .W_BITS(16), .ACC_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .spike_vec(spike0),
    .w_addr(w_addr0), .w_data(w_data0), .busy(busy0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_acc(out_acc0)
  );

  syn_accum #(.N_PRE(32), .W_BITS(16), .ACC_W(20)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .spike_vec(spike1),
    .w_addr(w_addr1), .w_data(w_data1), .busy(busy1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_acc(out_acc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous weight memories: data follows the address by one cycle.
  always @(posedge clk) begin
    w_data0 <= 16'(wt0[w_addr0]);
    w_data1 <= 16'(wt1[w_addr1]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Running saturating sum of the active weights, in input order.
  function automatic longint model(input int n, input int accw,
                                   input logic [31:0] spk, input int w[32]);
    longint s  = 0;
    longint hi = (longint'(1) <<< (accw - 1)) - 1;
    longint lo = -(longint'(1) <<< (accw - 1));
    for (int i = 0; i < n; i++) begin
      if (spk[i]) begin
        s = s + w[i];
        if (s > hi) s = hi;
        if (s < lo) s = lo;
      end
    end
    return s;
  endfunction

  // Monitors: compare every presented result, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid0) begin
      if (q0.size() == 0) chk("dut0_unexpected_valid", 1, 0);
      else begin
        chk("dut0_out_acc", longint'(out_acc0), q0[0]);
        if (out_ready0) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1) begin
      if (q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
      else begin
        chk("dut1_out_acc", longint'(out_acc1), q1[0]);
        if (out_ready1) void'(q1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sweep on instance 0 from idle; rdly cycles of backpressure in HOLD,
  // optional start pulse in the transfer cycle.
  task automatic sweep0(input logic [15:0] spk, input int rdly, input bit xfer_start);
    int lat = -1;
    int addr_ok = 1;
    int hold_ok = 1;
    start0 = 1'b1;
    spike0 = spk;
    q0.push_back(model(16, 32, 32'(spk), wt0));
    step();
    for (int k = 0; k < 40 && lat < 0; k++) begin
      start0 = 1'($urandom_range(0, 1));
      spike0 = 16'($urandom);
      if (k < 16 && w_addr0 != 4'(k)) addr_ok = 0;
      if (out_valid0) lat = k;
      else step();
    end
    chk("dut0_addr_seq", addr_ok, 1);
    chk("dut0_latency", lat, 17);
    if (lat < 0) begin
      q0.delete();
      start0 = 1'b0;
      return;
    end
    for (int c = 0; c < rdly; c++) begin
      start0 = c[0];
      spike0 = 16'($urandom);
      step();
      if (!busy0 || !out_valid0 || w_addr0 != 4'd0) hold_ok = 0;
    end
    chk("dut0_hold", hold_ok, 1);
    start0 = xfer_start;
    out_ready0 = 1'b1;
    step();
    chk("dut0_release", {30'd0, out_valid0, busy0}, 0);
    out_ready0 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic sweep1(input logic [31:0] spk);
    int lat = -1;
    start1 = 1'b1;
    spike1 = spk;
    q1.push_back(model(32, 20, spk, wt1));
    step();
    start1 = 1'b0;
    spike1 = $urandom;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      if (out_valid1) lat = k;
      else step();
    end
    chk("dut1_latency", lat, 33);
    if (lat < 0) begin
      q1.delete();
      return;
    end
    out_ready1 = 1'b1;
    step();
    chk("dut1_release", {30'd0, out_valid1, busy1}, 0);
    out_ready1 = 1'b0;
  endtask

  initial begin
    int quiet;
    rst_n = 1'b1;
    start0 = 1'b0; spike0 = '0; out_ready0 = 1'b0;
    start1 = 1'b0; spike1 = '0; out_ready1 = 1'b0;
    for (int i = 0; i < 32; i++) begin wt0[i] = 0; wt1[i] = 0; end

    // Asynchronous power-on reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_dut0", {busy0, out_valid0, 4'(w_addr0), out_acc0}, 0);
    chk("reset_dut1", {busy1, out_valid1, 5'(w_addr1), out_acc1}, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic sum: w[i]=100*i, spikes at 0 and 2.
    for (int i = 0; i < 16; i++) wt0[i] = 100 * i;
    sweep0(16'h0005, 0, 1'b0);
    // Full positive and negative.
    for (int i = 0; i < 16; i++) wt0[i] = 32767;
    sweep0(16'hFFFF, 1, 1'b0);
    for (int i = 0; i < 16; i++) wt0[i] = -32768;
    sweep0(16'hFFFF, 0, 1'b0);
    // All-zero spikes still sweep with fixed latency.
    sweep0(16'h0000, 0, 1'b0);
    // Backpressure with start in transfer cycle, then immediate restart.
    for (int i = 0; i < 16; i++) wt0[i] = int'($urandom_range(0, 65535)) - 32768;
    sweep0(16'($urandom), 5, 1'b1);
    sweep0(16'($urandom), 2, 1'b0);
    // Randomized sweeps.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) wt0[i] = int'($urandom_range(0, 65535)) - 32768;
      sweep0(16'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset mid-sweep: known nonzero result first, then abort.
    for (int i = 0; i < 16; i++) wt0[i] = 100 * i;
    sweep0(16'h0005, 0, 1'b0);
    start0 = 1'b1;
    spike0 = 16'hFFFF;
    step();
    start0 = 1'b0;
    for (int k = 0; k < 6; k++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_sweep", {busy0, out_valid0, 4'(w_addr0), out_acc0}, 0);
    q0.delete();
    step(); step();
    rst_n = 1'b1;
    quiet = 1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (out_valid0 || busy0) quiet = 0;
    end
    chk("reset_no_output", quiet, 1);
    sweep0(16'hFFFF, 0, 1'b0);

    // Saturation on the narrow accumulator.
    for (int i = 0; i < 32; i++) wt1[i] = 32767;
    sweep1(32'hFFFF_FFFF);
    wt1[31] = -32768;
    sweep1(32'hFFFF_FFFF);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) wt1[i] = int'($urandom_range(0, 65535)) - 32768;
      sweep1($urandom);
    end

    step(); step();
    chk("dut0_queue_empty", q0.size(), 0);
    chk("dut1_queue_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
